// File: rtl/nbit_updown_counter_mod.sv
// nbit_updown_counter_mod: SIZE-bit up/down counter with programmable step and
// limit, wrap/saturate bounds, parallel load, terminal-count pulse and sticky overflow.
`default_nettype none

module nbit_updown_counter_mod #(
  parameter int SIZE = 8
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            ce_i,
  input  logic            sr_i,
  input  logic [SIZE-1:0] srinit_i,
  input  logic            load_i,
  input  logic [SIZE-1:0] din_i,
  input  logic            up_i,
  input  logic [SIZE-1:0] step_i,
  input  logic [SIZE-1:0] limit_i,
  input  logic            mode_sat_i,
  input  logic            clr_ovf_i,
  output logic [SIZE-1:0] dout_o,
  output logic            tc_o,
  output logic            ovf_o
);

  localparam int W = SIZE + 1;

  logic [SIZE-1:0] dout_q, dout_d;
  logic            tc_q, tc_d;
  logic            ovf_q, ovf_d;

  logic [W-1:0]    dout_w, step_w, lim_w, lim_p1, sum, up_wrap, dn_gap;
  logic [SIZE-1:0] dn_wrap;
  logic            step_nz, event_hit;

  // One extra bit so sums and LIMIT+1 never truncate before comparison.
  assign dout_w  = {1'b0, dout_q};
  assign step_w  = {1'b0, step_i};
  assign lim_w   = {1'b0, limit_i};
  assign lim_p1  = lim_w + W'(1);
  assign sum     = dout_w + step_w;
  assign up_wrap = sum - lim_p1;
  assign dn_gap  = step_w - dout_w;
  assign dn_wrap = limit_i + SIZE'(1) - dn_gap[SIZE-1:0];
  assign step_nz = |step_i;

  always_comb begin
    dout_d    = dout_q;
    tc_d      = 1'b0;
    ovf_d     = ovf_q;
    event_hit = 1'b0;

    if (sr_i) begin
      dout_d = srinit_i;
    end else if (load_i) begin
      dout_d = din_i;
    end else if (ce_i && step_nz) begin
      if (up_i) begin
        if (sum > lim_w) begin
          event_hit = 1'b1;
          if (mode_sat_i)          dout_d = limit_i;
          else if (up_wrap > lim_w) dout_d = '0;
          else                      dout_d = up_wrap[SIZE-1:0];
        end else begin
          dout_d = sum[SIZE-1:0];
        end
      end else begin
        if (dout_q >= step_i) begin
          dout_d = dout_q - step_i;
        end else begin
          event_hit = 1'b1;
          if (mode_sat_i)          dout_d = '0;
          else if (dn_gap > lim_p1) dout_d = limit_i;
          else                      dout_d = dn_wrap;
        end
      end
    end

    tc_d = event_hit;
    // A same-cycle event beats CLR_OVF; SR clears unconditionally.
    if (sr_i)           ovf_d = 1'b0;
    else if (event_hit) ovf_d = 1'b1;
    else if (clr_ovf_i) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      dout_q <= '0;
      tc_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      tc_q   <= tc_d;
      ovf_q  <= ovf_d;
    end
  end

  assign dout_o = dout_q;
  assign tc_o   = tc_q;
  assign ovf_o  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_nbit_updown_counter_mod.sv
// Directed scoreboard bench for nbit_updown_counter_mod (SIZE=8).
`default_nettype none

module tb_nbit_updown_counter_mod;

  localparam int SIZE = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            ce = 0, sr = 0, load = 0, up = 1, mode_sat = 0, clr_ovf = 0;
  logic [SIZE-1:0] srinit = '0, din = '0, step = 8'd1, limit = 8'd9;
  logic [SIZE-1:0] dout;
  logic            tc, ovf;

  typedef struct {
    int dout;
    int tc;
    int ovf;
    string tag;
  } exp_t;

  exp_t exp_q[$];
  int   ncmp = 0;
  int   nfail = 0;
  int   m_dout = 0, m_tc = 0, m_ovf = 0;

  nbit_updown_counter_mod #(.SIZE(SIZE)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .ce_i(ce), .sr_i(sr), .srinit_i(srinit),
    .load_i(load), .din_i(din), .up_i(up), .step_i(step), .limit_i(limit),
    .mode_sat_i(mode_sat), .clr_ovf_i(clr_ovf),
    .dout_o(dout), .tc_o(tc), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    ncmp++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Behavioural reference computed from the specification with plain integers.
  task automatic model_step();
    int s, r, lim, st, ev;
    lim = int'(limit);
    st  = int'(step);
    ev  = 0;
    if (sr) begin
      m_dout = int'(srinit); m_tc = 0; m_ovf = 0;
      return;
    end
    if (load) begin
      m_dout = int'(din);
    end else if (ce && st != 0) begin
      if (up) begin
        s = m_dout + st;
        if (s > lim) begin
          ev = 1;
          if (mode_sat) m_dout = lim;
          else begin
            r = s - (lim + 1);
            m_dout = (r > lim) ? 0 : r;
          end
        end else m_dout = s;
      end else begin
        if (m_dout >= st) m_dout = m_dout - st;
        else begin
          ev = 1;
          if (mode_sat) m_dout = 0;
          else begin
            r = (lim + 1) - (st - m_dout);
            m_dout = (r < 0) ? lim : r;
          end
        end
      end
    end
    m_tc = ev;
    if (ev) m_ovf = 1;
    else if (clr_ovf) m_ovf = 0;
  endtask

  // Drive one edge: push the model's prediction, then pop and compare after the edge.
  task automatic cyc(input string tag);
    exp_t e;
    model_step();
    e.dout = m_dout; e.tc = m_tc; e.ovf = m_ovf; e.tag = tag;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({e.tag, ".dout"}, 32'(dout), 32'(e.dout));
    chk({e.tag, ".tc"},   32'(tc),   32'(e.tc));
    chk({e.tag, ".ovf"},  32'(ovf),  32'(e.ovf));
  endtask

  task automatic idle();
    ce = 0; sr = 0; load = 0; clr_ovf = 0;
  endtask

  initial begin
    // Async reset assertion and reset state
    #2 rst_n = 1'b0;
    #1;
    chk("reset.dout", 32'(dout), 32'd0);
    chk("reset.tc",   32'(tc),   32'd0);
    chk("reset.ovf",  32'(ovf),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: wrap 0..9 -> 0 with TC and OVF
    limit = 8'd9; step = 8'd1; up = 1; mode_sat = 0; ce = 1;
    for (int i = 0; i < 11; i++) cyc($sformatf("t1_%0d", i));

    // 2: down saturate from 10 by 7
    idle(); limit = 8'd200; step = 8'd7; up = 0; mode_sat = 1;
    load = 1; din = 8'd10; cyc("t2_load");
    idle(); ce = 1;
    for (int i = 0; i < 3; i++) cyc($sformatf("t2_dn%0d", i));
    idle(); clr_ovf = 1; cyc("t2_clr");

    // 3: wrap up past 255, then wrap down
    idle(); limit = 8'd255; step = 8'd100; up = 1; mode_sat = 0;
    load = 1; din = 8'd200; cyc("t3_load");
    idle(); ce = 1; cyc("t3_up");
    up = 0; step = 8'd50; cyc("t3_dn");

    // 4: SR beats LOAD beats CE; LOAD keeps OVF
    idle(); sr = 1; load = 1; ce = 1; srinit = 8'd5; din = 8'd9; cyc("t4_prio");
    idle(); limit = 8'd5; step = 8'd1; up = 1; ce = 1; cyc("t4_ev");
    idle(); load = 1; din = 8'd9; cyc("t4_load");
    idle(); clr_ovf = 1; ce = 1; up = 1; cyc("t4_set_wins");

    // 5: async reset mid-count
    idle(); limit = 8'd20; step = 8'd1; up = 1; mode_sat = 0;
    load = 1; din = 8'd0; cyc("t5_load");
    idle(); ce = 1;
    for (int i = 0; i < 6; i++) cyc($sformatf("t5_up%0d", i));
    #2 rst_n = 1'b0;
    m_dout = 0; m_tc = 0; m_ovf = 0;
    #1;
    chk("t5_rst.dout", 32'(dout), 32'd0);
    chk("t5_rst.tc",   32'(tc),   32'd0);
    chk("t5_rst.ovf",  32'(ovf),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("t5_resume");

    // 6: out-of-range load, wrap result still high -> 0; STEP=0 holds
    idle(); limit = 8'd20; load = 1; din = 8'd50; cyc("t6_load");
    idle(); ce = 1; step = 8'd1; up = 1; mode_sat = 0; cyc("t6_up");
    step = 8'd0; cyc("t6_step0");

    // Saturate repeatedly at the top bound, then LIMIT=0
    step = 8'd3; mode_sat = 1; limit = 8'd4;
    for (int i = 0; i < 4; i++) cyc($sformatf("sat_%0d", i));
    limit = 8'd0; mode_sat = 0; cyc("lim0_a"); cyc("lim0_b");
    up = 0; step = 8'd1; cyc("lim0_dn");
    up = 0; limit = 8'd10; step = 8'd30; cyc("dn_big");

    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

`default_nettype wire
